// File: rtl/bcd_time_counter.sv
// mm:ss BCD up/down time counter with synchronous preset, hold-or-wrap terminal
// behaviour and a lap freeze that latches the displayed value while counting continues.
module bcd_time_counter #(
  parameter int unsigned MAX_MIN = 59,
  parameter int unsigned WRAP    = 0
) (
  input  logic       clk_1hz,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       lap,
  output logic [3:0] led_0,
  output logic [3:0] led_1,
  output logic [3:0] led_2,
  output logic [3:0] led_3,
  output logic       done
);

  localparam logic [3:0]  MaxMinH   = 4'(MAX_MIN / 10);
  localparam logic [3:0]  MaxMinL   = 4'(MAX_MIN % 10);
  localparam logic [7:0]  MaxMinBcd = {MaxMinH, MaxMinL};
  localparam logic [15:0] TopBcd    = {MaxMinBcd, 8'h59};

  // cnt packed as {min_h, min_l, sec_h, sec_l}
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] snap_q, snap_d;
  logic        lap_q, lap_d;

  logic [3:0]  sec_l, sec_h, min_l, min_h;
  logic [15:0] cnt_inc, cnt_dec;
  logic        at_top, at_zero;
  logic        ld_digits_ok, ld_ok;
  logic [15:0] disp;

  assign sec_l = cnt_q[3:0];
  assign sec_h = cnt_q[7:4];
  assign min_l = cnt_q[11:8];
  assign min_h = cnt_q[15:12];

  assign at_top  = (cnt_q == TopBcd);
  assign at_zero = (cnt_q == 16'h0000);

  // Digit-wise compares are only meaningful once every nibble is a legal BCD digit.
  always_comb begin
    ld_digits_ok = (load_min[7:4] <= 4'd9) && (load_min[3:0] <= 4'd9) &&
                   (load_sec[7:4] <= 4'd9) && (load_sec[3:0] <= 4'd9);
    ld_ok        = ld_digits_ok && (load_sec <= 8'h59) && (load_min <= MaxMinBcd);
  end

  // +1 s with BCD carries; the terminal case is handled by the caller.
  always_comb begin
    cnt_inc = cnt_q;
    if (sec_l != 4'd9) begin
      cnt_inc[3:0] = sec_l + 4'd1;
    end else begin
      cnt_inc[3:0] = 4'd0;
      if (sec_h != 4'd5) begin
        cnt_inc[7:4] = sec_h + 4'd1;
      end else begin
        cnt_inc[7:4] = 4'd0;
        if (min_l != 4'd9) begin
          cnt_inc[11:8] = min_l + 4'd1;
        end else begin
          cnt_inc[11:8]  = 4'd0;
          cnt_inc[15:12] = min_h + 4'd1;
        end
      end
    end
  end

  // -1 s with BCD borrows; 00:00 is handled by the caller.
  always_comb begin
    cnt_dec = cnt_q;
    if (sec_l != 4'd0) begin
      cnt_dec[3:0] = sec_l - 4'd1;
    end else begin
      cnt_dec[3:0] = 4'd9;
      if (sec_h != 4'd0) begin
        cnt_dec[7:4] = sec_h - 4'd1;
      end else begin
        cnt_dec[7:4] = 4'd5;
        if (min_l != 4'd0) begin
          cnt_dec[11:8] = min_l - 4'd1;
        end else begin
          cnt_dec[11:8]  = 4'd9;
          cnt_dec[15:12] = min_h - 4'd1;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      // An invalid preset still blocks counting on this edge.
      if (ld_ok) begin
        cnt_d = {load_min, load_sec};
      end
    end else if (en) begin
      if (!dir) begin
        if (at_top) begin
          cnt_d = (WRAP != 0) ? 16'h0000 : cnt_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        if (at_zero) begin
          cnt_d = (WRAP != 0) ? TopBcd : cnt_q;
        end else begin
          cnt_d = cnt_dec;
        end
      end
    end
  end

  always_comb begin
    lap_d  = lap;
    snap_d = snap_q;
    if (lap && !lap_q) begin
      snap_d = cnt_q;
    end
  end

  always_ff @(posedge clk_1hz or posedge rst) begin
    if (rst) begin
      cnt_q  <= 16'h0000;
      snap_q <= 16'h0000;
      lap_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
      lap_q  <= lap_d;
    end
  end

  always_comb begin
    disp  = lap_q ? snap_q : cnt_q;
    led_0 = disp[3:0];
    led_1 = disp[7:4];
    led_2 = disp[11:8];
    led_3 = disp[15:12];
    done  = dir ? at_zero : at_top;
  end

endmodule

// File: doc/bcd_time_counter.md
BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

Interface
REQ-001 The block SHALL have parameter MAX_MIN, default 59, meaning the highest minute value (decimal, legal range 1..99).
REQ-002 The block SHALL have parameter WRAP, default 0, meaning terminal behaviour: 0 = hold at terminal, 1 = wrap around.
REQ-003 The block SHALL have port clk_1hz, input, 1 bit: count clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port en, input, 1 bit: count enable; 0 = pause.
REQ-006 The block SHALL have port dir, input, 1 bit: 0 = count up, 1 = count down.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous preset request.
REQ-008 The block SHALL have port load_min, input, 8 bits: preset minutes as two BCD digits, [7:4] tens and [3:0] units.
REQ-009 The block SHALL have port load_sec, input, 8 bits: preset seconds as two BCD digits, [7:4] tens and [3:0] units.
REQ-010 The block SHALL have port lap, input, 1 bit: level input; 1 = freeze the displayed value while counting continues.
REQ-011 The block SHALL have ports led_0, led_1, led_2 and led_3, output, 4 bits each: displayed seconds units, seconds tens, minutes units and minutes tens.
REQ-012 The block SHALL have port done, output, 1 bit: internal count is at the terminal value for the current dir.

Function
REQ-013 The block SHALL hold the internal count cnt as four BCD digits mm:ss; every digit SHALL stay 0..9, seconds SHALL stay 00..59 and minutes SHALL stay 00..MAX_MIN.
REQ-014 Per edge, priority SHALL be: load > en; with en=0 and load=0, cnt SHALL hold.
REQ-015 A load SHALL be valid when all four digits are 0..9, load_sec <= 59 and load_min <= MAX_MIN; a valid load SHALL set cnt to load_min:load_sec on that edge, regardless of en.
REQ-016 An invalid load SHALL be ignored, leaving cnt unchanged and suppressing counting on that edge.
REQ-017 Count-up (en=1, dir=0) SHALL step by +1 s: sec_l 9->0 carries to sec_h, sec_h 5->0 carries to min_l, min_l 9->0 carries to min_h.
REQ-018 Count-down (en=1, dir=1) SHALL step by -1 s: sec_l 0->9 borrows from sec_h, sec_h 0->5 borrows from min_l, min_l 0->9 borrows from min_h.
REQ-019 The up terminal SHALL be MAX_MIN:59; with WRAP=0, cnt SHALL hold at the terminal, and with WRAP=1 the next step SHALL go to 00:00.
REQ-020 The down terminal SHALL be 00:00; with WRAP=0, cnt SHALL hold at the terminal, and with WRAP=1 the next step SHALL go to MAX_MIN:59.
REQ-021 done SHALL be combinational from cnt and dir: 1 iff cnt equals the terminal for the current dir; a change of dir SHALL re-evaluate done immediately.
REQ-022 The lap path SHALL register lap as lap_q every edge; on an edge where lap=1 and lap_q=0, snap SHALL capture the pre-update value of cnt.
REQ-023 Outputs SHALL show snap while lap_q=1 and cnt otherwise; releasing lap SHALL show the live cnt from the next edge.
REQ-024 The lap freeze SHALL have no effect on counting, load, or done; done always reflects the live cnt.
REQ-025 A load while lap_q=1 SHALL update cnt but not snap.
REQ-026 A change of dir mid-count SHALL take effect on the next edge, with no lost or duplicated step.

Reset
REQ-027 While rst=1, cnt SHALL be 00:00, snap SHALL be 00:00, lap_q SHALL be 0, and led_0..led_3 SHALL all be 0, independent of the clock.
REQ-028 During reset, done SHALL be 1 when dir=1 and 0 when dir=0.
REQ-029 Reset asserted mid-count or mid-lap SHALL clear all state immediately; counting SHALL resume from 00:00 on the first edge after rst falls, if en=1.

Verification
REQ-030 The bench SHALL cover up-count rollover with MAX_MIN=59, WRAP=0: en=1, dir=0 from 00:00 for 3599 edges gives 59:59 with done=1, and a further 5 edges still give 59:59.
REQ-031 The bench SHALL cover wrap: WRAP=1, load 59:59, then 1 up edge gives 00:00 with done=0; load 00:00, dir=1, then 1 edge gives 59:59.
REQ-032 The bench SHALL cover down-count borrow: load 10:00, dir=1, then 1 edge gives 09:59, and 600 edges total give 00:00 with done=1, held.
REQ-033 The bench SHALL cover invalid load: load_sec=8'h60, then cnt is unchanged and counting is suppressed on that edge; load_min=8'h1A gives the same result.
REQ-034 The bench SHALL cover lap: counting up from 00:10, raise lap, and outputs freeze at 00:10 for 20 edges; drop lap and outputs show 00:31 after the next edge.
REQ-035 The bench SHALL cover asynchronous reset: assert rst mid-edge-interval at 12:34 and outputs go to 00:00 before the next clk_1hz edge.
